amba_ahb_s2m_mux: RTL and testbench

AMBA_AHB_S2M_MUX -- requirements
Module: amba_ahb_s2m_mux

---
 rtl/amba_ahb_s2m_mux.sv | 117 +++++++++++
 tb/tb_amba_ahb_s2m_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_s2m_mux.sv
// rtl/amba_ahb_s2m_mux.sv - AHB slave-to-master response mux with built-in default (error) slave
module amba_ahb_s2m_mux #(
    parameter int N_SLAVE = 2,
    parameter int W_SLAVE = 1,
    parameter int W_DATA  = 32,
    parameter int W_CNT   = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [N_SLAVE-1:0]        HSEL,
    input  logic [W_SLAVE-1:0]        HSLAVE,
    input  logic [1:0]                HTRANS,
    input  logic [N_SLAVE*W_DATA-1:0] HRDATA_S,
    input  logic [N_SLAVE-1:0]        HREADYOUT_S,
    input  logic [N_SLAVE*2-1:0]      HRESP_S,
    output logic [W_DATA-1:0]         HRDATA,
    output logic                      HREADY,
    output logic [1:0]                HRESP,
    output logic [W_CNT-1:0]          ERR_CNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t               state;
    state_t               state_nxt;
    logic [W_SLAVE-1:0]   dp_slave;
    logic                 dp_mapped;
    logic                 dp_unmapped_act;

    // An out-of-range slave index is routed to the default slave, same as an empty HSEL
    logic mapped_in;
    logic unmapped_act_in;
    assign mapped_in       = (|HSEL) && (32'(HSLAVE) < 32'(N_SLAVE));
    assign unmapped_act_in = !mapped_in && HTRANS[1];

    // Capture the address-phase decode for the data phase; hold while the bus is stalled
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_slave        <= '0;
            dp_mapped       <= 1'b0;
            dp_unmapped_act <= 1'b0;
        end else if (HREADY) begin
            dp_slave        <= HSLAVE;
            dp_mapped       <= mapped_in;
            dp_unmapped_act <= unmapped_act_in;
        end
    end

    // Default-slave state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Default-slave next state: two-cycle ERROR for every active transfer to unmapped space
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (HREADY && unmapped_act_in) begin
                    state_nxt = S_ERR1;
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                state_nxt = unmapped_act_in ? S_ERR1 : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Error counter: one count per completed first error cycle, saturating
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ERR_CNT <= '0;
        end else if (state == S_ERR1 && ERR_CNT != {W_CNT{1'b1}}) begin
            ERR_CNT <= ERR_CNT + 1'b1;
        end
    end

    // Output mux: selected slave when mapped, otherwise the default slave; no address-phase inputs used
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        if (dp_mapped) begin
            for (int i = 0; i < N_SLAVE; i++) begin
                if (32'(dp_slave) == 32'(i)) begin
                    HRDATA = HRDATA_S[i*W_DATA +: W_DATA];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i*2 +: 2];
                end
            end
        end else if (dp_unmapped_act && state == S_ERR1) begin
            HREADY = 1'b0;
            HRESP  = RESP_ERROR;
        end else if (dp_unmapped_act && state == S_ERR2) begin
            HREADY = 1'b1;
            HRESP  = RESP_ERROR;
        end
    end

endmodule

// File: tb/tb_amba_ahb_s2m_mux.sv
// tb/tb_amba_ahb_s2m_mux.sv - self-checking bench for amba_ahb_s2m_mux
module tb_amba_ahb_s2m_mux;

    localparam int N_SLAVE = 2;
    localparam int W_SLAVE = 1;
    localparam int W_DATA  = 32;
    localparam int W_CNT   = 4;

    logic                      HCLK;
    logic                      HRESET;
    logic [N_SLAVE-1:0]        HSEL;
    logic [W_SLAVE-1:0]        HSLAVE;
    logic [1:0]                HTRANS;
    logic [N_SLAVE*W_DATA-1:0] HRDATA_S;
    logic [N_SLAVE-1:0]        HREADYOUT_S;
    logic [N_SLAVE*2-1:0]      HRESP_S;
    logic [W_DATA-1:0]         HRDATA;
    logic                      HREADY;
    logic [1:0]                HRESP;
    logic [W_CNT-1:0]          ERR_CNT;

    int total = 0;
    int bad   = 0;

    // Reference model: data-phase owner plus remaining error-response cycles
    bit m_mapped;
    int m_slave;
    int m_err_left;   // 2: first (stalled) error cycle, 1: second error cycle, 0: none
    int m_cnt;
    int cnt_max = (1 << W_CNT) - 1;

    amba_ahb_s2m_mux #(
        .N_SLAVE(N_SLAVE), .W_SLAVE(W_SLAVE), .W_DATA(W_DATA), .W_CNT(W_CNT)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HSLAVE(HSLAVE), .HTRANS(HTRANS),
        .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .ERR_CNT(ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mapped   = 1'b0;
        m_slave    = 0;
        m_err_left = 0;
        m_cnt      = 0;
    endtask

    // Compare at the falling edge, then advance the model across the next rising edge
    task automatic step(input string tag);
        logic [31:0] e_data;
        logic        e_ready;
        logic [1:0]  e_resp;
        bit          mapped_in;
        @(negedge HCLK);
        if (m_mapped) begin
            e_data  = HRDATA_S[m_slave*W_DATA +: W_DATA];
            e_ready = HREADYOUT_S[m_slave];
            e_resp  = HRESP_S[m_slave*2 +: 2];
        end else begin
            e_data  = 32'h0;
            e_ready = (m_err_left != 2);
            e_resp  = (m_err_left != 0) ? 2'b01 : 2'b00;
        end
        chk({tag, ".hready"}, 32'(HREADY), 32'(e_ready));
        chk({tag, ".hresp"},  32'(HRESP),  32'(e_resp));
        chk({tag, ".hrdata"}, HRDATA, e_data);
        chk({tag, ".errcnt"}, 32'(ERR_CNT), 32'(m_cnt));
        if (HRESET) begin
            model_reset();
        end else begin
            if (!m_mapped && m_err_left == 2 && m_cnt < cnt_max) m_cnt++;
            if (e_ready) begin
                mapped_in  = (HSEL != 0) && (int'(HSLAVE) < N_SLAVE);
                m_mapped   = mapped_in;
                m_slave    = int'(HSLAVE);
                m_err_left = (!mapped_in && HTRANS[1]) ? 2 : 0;
            end else if (!m_mapped && m_err_left == 2) begin
                m_err_left = 1;
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] sel, input logic [0:0] slv, input logic [1:0] trans);
        HSEL   = sel;
        HSLAVE = slv;
        HTRANS = trans;
    endtask

    initial begin
        HRESET      = 1'b1;
        HSEL        = '0;
        HSLAVE      = '0;
        HTRANS      = 2'b00;
        HRDATA_S    = {32'hDEAD_BEE1, 32'hDEAD_BEE0};
        HREADYOUT_S = 2'b11;
        HRESP_S     = '0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Idle bus after reset
        step("rst0");
        step("rst1");

        // Mapped read from slave 1 with two wait states
        drive_addr(2'b10, 1'b1, 2'b10);
        step("m_addr");
        drive_addr(2'b00, 1'b0, 2'b00);
        HREADYOUT_S = 2'b01;
        HRDATA_S[32 +: 32] = 32'hA5A5_0001;
        step("m_wait1");
        step("m_wait2");
        HREADYOUT_S = 2'b11;
        step("m_done");
        chk("m_done.lit_cnt", 32'(ERR_CNT), 32'd0);

        // Single unmapped NONSEQ: ERR1, ERR2, then idle
        drive_addr(2'b00, 1'b0, 2'b10);
        step("u_addr");
        drive_addr(2'b00, 1'b0, 2'b00);
        chk("u_err1.lit_ready", 32'(HREADY), 32'd0);
        chk("u_err1.lit_resp", 32'(HRESP), 32'd1);
        step("u_err1");
        step("u_err2");
        step("u_idle");
        chk("u_idle.lit_cnt", 32'(ERR_CNT), 32'd1);

        // Back-to-back unmapped, second accepted in ERR2
        drive_addr(2'b00, 1'b0, 2'b10);
        step("bb_addr");
        step("bb_err1a");
        drive_addr(2'b00, 1'b0, 2'b11);
        step("bb_err2a");
        drive_addr(2'b00, 1'b0, 2'b00);
        step("bb_err1b");
        step("bb_err2b");
        step("bb_idle");
        chk("bb.lit_cnt", 32'(ERR_CNT), 32'd3);

        // Unmapped IDLE and BUSY transfers are zero-wait OKAY
        drive_addr(2'b00, 1'b0, 2'b00);
        step("ui_addr");
        drive_addr(2'b00, 1'b0, 2'b01);
        step("ub_addr");
        drive_addr(2'b00, 1'b0, 2'b00);
        step("ui_idle");
        chk("ui.lit_cnt", 32'(ERR_CNT), 32'd3);

        // Drive the counter to saturation and beyond
        for (int k = 0; k < 16; k++) begin
            drive_addr(2'b00, 1'b0, 2'b10);
            step("sat_addr");
            drive_addr(2'b00, 1'b0, 2'b00);
            step("sat_err1");
            step("sat_err2");
        end
        step("sat_idle");
        chk("sat.lit_cnt", 32'(ERR_CNT), 32'hF);

        // Reset while stalled in the first error cycle
        drive_addr(2'b00, 1'b0, 2'b10);
        step("re_addr");
        drive_addr(2'b00, 1'b0, 2'b00);
        HRESET = 1'b1;
        step("re_err1");
        HRESET = 1'b0;
        chk("re.lit_ready", 32'(HREADY), 32'd1);
        chk("re.lit_resp", 32'(HRESP), 32'd0);
        chk("re.lit_cnt", 32'(ERR_CNT), 32'd0);
        step("re_after");

        // Reset during a mapped slave wait state
        drive_addr(2'b01, 1'b0, 2'b10);
        step("rw_addr");
        drive_addr(2'b00, 1'b0, 2'b00);
        HREADYOUT_S = 2'b10;
        HRESET = 1'b1;
        step("rw_wait");
        HRESET = 1'b0;
        chk("rw.lit_ready", 32'(HREADY), 32'd1);
        chk("rw.lit_data", HRDATA, 32'd0);
        step("rw_after");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int pick;
            pick = $urandom_range(0, 2);
            HSEL   = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b10;
            HSLAVE = (pick == 2) ? 1'b1 : 1'b0;
            HTRANS = 2'($urandom_range(0, 3));
            HRDATA_S    = {$urandom, $urandom};
            HREADYOUT_S = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            HRESP_S     = {1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
            HRESET      = ($urandom_range(0, 49) == 0);
            step("rnd");
        end
        HRESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
